// File: rtl/exp_accel_arbiter_pkg.sv
// Shared types and constants for the exponential-accelerator arbiter.
// Holds the FSM state enum, the datapath widths and the default watchdog limit.
package exp_arb_pkg;

  localparam int unsigned DATA_W              = 16;
  localparam int unsigned INT_W               = 2;
  localparam int unsigned TIMEOUT_CYC_DEFAULT = 256;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_t;

endpackage

// File: rtl/exp_accel_arbiter_if.sv
// Requester-side and accelerator-side signals of the arbiter, bundled as one interface.
// master = arbiter view, slave = client/accelerator environment view.
interface exp_accel_arbiter_if
  import exp_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0][DATA_W-1:0] x_in;
  logic [N_REQ-1:0]             ack;
  logic                         res_valid;
  logic [INT_W-1:0]             res_intpart;
  logic [DATA_W-1:0]            res_fracpart;
  logic                         res_err;
  logic                         busy;
  logic                         acc_start;
  logic [DATA_W-1:0]            acc_x;
  logic                         acc_done;
  logic [INT_W-1:0]             acc_intpart;
  logic [DATA_W-1:0]            acc_fracpart;

  modport master (
    input  req, x_in, acc_done, acc_intpart, acc_fracpart,
    output ack, res_valid, res_intpart, res_fracpart, res_err, busy, acc_start, acc_x
  );

  modport slave (
    output req, x_in, acc_done, acc_intpart, acc_fracpart,
    input  ack, res_valid, res_intpart, res_fracpart, res_err, busy, acc_start, acc_x
  );

endinterface

// File: rtl/exp_accel_arbiter_rr_picker.sv
// Combinational rotating-priority selector: first set request at or after i_ptr,
// wrapping modulo N_REQ, is granted one-hot.
module rr_picker #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IdW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IdW-1:0]   i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_valid
);

  localparam logic [IdW:0] NReqW = (IdW + 1)'(N_REQ);

  logic [IdW:0] w_sum;

  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      w_sum = {1'b0, i_ptr} + off[IdW:0];
      if (w_sum >= NReqW) w_sum = w_sum - NReqW;
      if (!o_valid && i_req[w_sum[IdW-1:0]]) begin
        o_gnt[w_sum[IdW-1:0]] = 1'b1;
        o_valid               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exp_accel_arbiter.sv
// Round-robin arbiter/sequencer sharing one exponential accelerator among N_REQ requesters.
// Optional WAIT watchdog built only when EXP_ARB_TIMEOUT_EN is defined.
module exp_accel_arbiter
  import exp_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  exp_accel_arbiter_if.master bus
);

  localparam int unsigned    IdW    = $clog2(N_REQ);
  localparam logic [IdW-1:0] LastId = IdW'(N_REQ - 1);

  arb_state_t        r_state, w_state_nxt;
  logic [IdW-1:0]    r_id, w_id_nxt;
  logic [IdW-1:0]    r_ptr, w_ptr_nxt;
  logic [DATA_W-1:0] r_x, w_x_nxt;
  logic              r_first, w_first_nxt;
  logic              r_start, w_start_nxt;
  logic [N_REQ-1:0]  r_ack, w_ack_nxt;
  logic              r_valid, w_valid_nxt;
  logic [INT_W-1:0]  r_int, w_int_nxt;
  logic [DATA_W-1:0] r_frac, w_frac_nxt;
  logic              r_err, w_err_nxt;
  logic              r_busy, w_busy_nxt;

  logic [N_REQ-1:0]  w_gnt;
  logic              w_pick_valid;
  logic [IdW-1:0]    w_gnt_id;
  logic              w_timeout;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) w_gnt_id = i[IdW-1:0];
    end
  end

`ifdef EXP_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                    r_cnt <= '0;
    else if (r_state == StIssue) r_cnt <= '0;
    else if (r_state == StWait)  r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state == StWait) && (r_cnt == CntW'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_ptr_nxt   = r_ptr;
    w_x_nxt     = r_x;
    w_first_nxt = 1'b0;
    w_start_nxt = 1'b0;
    w_ack_nxt   = '0;
    w_valid_nxt = 1'b0;
    w_int_nxt   = r_int;
    w_frac_nxt  = r_frac;
    w_err_nxt   = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_id_nxt    = w_gnt_id;
          w_x_nxt     = bus.x_in[w_gnt_id];
          w_start_nxt = 1'b1;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        w_first_nxt = 1'b1;
        w_state_nxt = StWait;
      end
      StWait: begin
        // The accelerator may still be showing done from its idle state in the first cycle.
        if (!r_first && bus.acc_done) begin
          w_int_nxt        = bus.acc_intpart;
          w_frac_nxt       = bus.acc_fracpart;
          w_err_nxt        = 1'b0;
          w_ack_nxt[r_id]  = 1'b1;
          w_valid_nxt      = 1'b1;
          w_state_nxt      = StResp;
        end else if (w_timeout) begin
          w_int_nxt        = '0;
          w_frac_nxt       = '0;
          w_err_nxt        = 1'b1;
          w_ack_nxt[r_id]  = 1'b1;
          w_valid_nxt      = 1'b1;
          w_state_nxt      = StResp;
        end
      end
      StResp: begin
        w_ptr_nxt   = (r_id == LastId) ? '0 : r_id + 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    w_busy_nxt = (w_state_nxt != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_id    <= '0;
      r_ptr   <= '0;
      r_x     <= '0;
      r_first <= 1'b0;
      r_start <= 1'b0;
      r_ack   <= '0;
      r_valid <= 1'b0;
      r_int   <= '0;
      r_frac  <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      r_ptr   <= w_ptr_nxt;
      r_x     <= w_x_nxt;
      r_first <= w_first_nxt;
      r_start <= w_start_nxt;
      r_ack   <= w_ack_nxt;
      r_valid <= w_valid_nxt;
      r_int   <= w_int_nxt;
      r_frac  <= w_frac_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.ack          = r_ack;
  assign bus.res_valid    = r_valid;
  assign bus.res_intpart  = r_int;
  assign bus.res_fracpart = r_frac;
  assign bus.res_err      = r_err;
  assign bus.busy         = r_busy;
  assign bus.acc_start    = r_start;
  assign bus.acc_x        = r_x;

endmodule
